// File: rtl/rotate_pkg.sv
// rtl/rotate_pkg.sv - shared axis encoding and default widths for the vertex rotator
package rotate_pkg;

    typedef enum logic [1:0] {
        AXIS_X    = 2'd0,
        AXIS_Y    = 2'd1,
        AXIS_Z    = 2'd2,
        AXIS_NONE = 2'd3
    } axis_e;

    localparam int DEF_COORD_W = 8;
    localparam int DEF_TRIG_W  = 16;
    localparam int DEF_FRAC    = 8;
    localparam int DEF_TAG_W   = 8;

endpackage

// File: rtl/rot_pair.sv
// rtl/rot_pair.sv - one 2-D rotation: registered products, then add, round half-up and limit
// Optional clamping enabled by macro VERTEX_ROTATOR_SAT_EN; default build wraps.
module rot_pair
    import rotate_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int TRIG_W  = DEF_TRIG_W,
    parameter int FRAC    = DEF_FRAC,
    parameter int OUT_W   = COORD_W + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic signed [COORD_W-1:0] a,
    input  logic signed [COORD_W-1:0] b,
    input  logic signed [TRIG_W-1:0]  sin_v,
    input  logic signed [TRIG_W-1:0]  cos_v,
    output logic signed [OUT_W-1:0]   r0,
    output logic signed [OUT_W-1:0]   r1
);

    localparam int P_W = COORD_W + TRIG_W;
    localparam int S_W = P_W + 1;
    localparam logic signed [S_W-1:0] HALF = S_W'(2 ** (FRAC - 1));

    logic signed [P_W-1:0] ac_d, ac_q, bs_d, bs_q, as_d, as_q, bc_d, bc_q;
    logic signed [S_W-1:0] rnd0, rnd1;

    always_comb begin
        ac_d = ac_q;
        bs_d = bs_q;
        as_d = as_q;
        bc_d = bc_q;
        if (en) begin
            ac_d = P_W'(a) * P_W'(cos_v);
            bs_d = P_W'(b) * P_W'(sin_v);
            as_d = P_W'(a) * P_W'(sin_v);
            bc_d = P_W'(b) * P_W'(cos_v);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q <= '0;
            bs_q <= '0;
            as_q <= '0;
            bc_q <= '0;
        end else begin
            ac_q <= ac_d;
            bs_q <= bs_d;
            as_q <= as_d;
            bc_q <= bc_d;
        end
    end

    assign rnd0 = S_W'(ac_q) - S_W'(bs_q) + HALF;
    assign rnd1 = S_W'(as_q) + S_W'(bc_q) + HALF;

`ifdef VERTEX_ROTATOR_SAT_EN
    localparam logic signed [S_W-1:0] MAX_V = S_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [S_W-1:0] MIN_V = ~MAX_V;

    function automatic logic signed [OUT_W-1:0] limit(input logic signed [S_W-1:0] v);
        logic signed [S_W-1:0] sh;
        sh = v >>> FRAC;
        if (sh > MAX_V)
            return OUT_W'(MAX_V);
        else if (sh < MIN_V)
            return OUT_W'(MIN_V);
        else
            return OUT_W'(sh);
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] limit(input logic signed [S_W-1:0] v);
        return OUT_W'(v >>> FRAC);
    endfunction
`endif

    assign r0 = limit(rnd0);
    assign r1 = limit(rnd1);

endmodule

// File: rtl/vertex_rotator.sv
// rtl/vertex_rotator.sv - 3-stage streaming vertex rotation about X, Y, Z or identity
// Macro VERTEX_ROTATOR_SAT_EN selects clamping of rotated results instead of wrapping.
module vertex_rotator
    import rotate_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int TRIG_W  = DEF_TRIG_W,
    parameter int FRAC    = DEF_FRAC,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [COORD_W-1:0]   in_x,
    input  logic signed [COORD_W-1:0]   in_y,
    input  logic signed [COORD_W-1:0]   in_z,
    input  logic signed [TRIG_W-1:0]    in_sin,
    input  logic signed [TRIG_W-1:0]    in_cos,
    input  logic [1:0]                  in_axis,
    input  logic [TAG_W-1:0]            in_tag,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [COORD_W:0]     out_x,
    output logic signed [COORD_W:0]     out_y,
    output logic signed [COORD_W:0]     out_z,
    output logic [TAG_W-1:0]            out_tag,
    output logic                        out_last
);

    localparam int OUT_W = COORD_W + 1;

    logic adv;

    // stage 1: registered input beat
    logic                      v1_d, v1_q, last1_d, last1_q;
    logic signed [COORD_W-1:0] x1_d, x1_q, y1_d, y1_q, z1_d, z1_q;
    logic signed [TRIG_W-1:0]  sin1_d, sin1_q, cos1_d, cos1_q;
    axis_e                     axis1_d, axis1_q;
    logic [TAG_W-1:0]          tag1_d, tag1_q;

    // stage 2: products live inside rot_pair; coordinates ride along for passthrough
    logic                      v2_d, v2_q, last2_d, last2_q;
    logic signed [COORD_W-1:0] x2_d, x2_q, y2_d, y2_q, z2_d, z2_q;
    axis_e                     axis2_d, axis2_q;
    logic [TAG_W-1:0]          tag2_d, tag2_q;

    // stage 3: output register
    logic                      out_valid_d, out_valid_q, out_last_d, out_last_q;
    logic signed [OUT_W-1:0]   out_x_d, out_x_q, out_y_d, out_y_q, out_z_d, out_z_q;
    logic [TAG_W-1:0]          out_tag_d, out_tag_q;

    logic signed [COORD_W-1:0] rot_a, rot_b;
    logic signed [OUT_W-1:0]   rot_r0, rot_r1;
    logic signed [OUT_W-1:0]   ext_x, ext_y, ext_z;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv || rst;

    always_comb begin
        rot_a = x1_q;
        rot_b = y1_q;
        case (axis1_q)
            AXIS_X: begin
                rot_a = y1_q;
                rot_b = z1_q;
            end
            AXIS_Y: begin
                rot_a = z1_q;
                rot_b = x1_q;
            end
            default: begin
                rot_a = x1_q;
                rot_b = y1_q;
            end
        endcase
    end

    rot_pair #(
        .COORD_W (COORD_W),
        .TRIG_W  (TRIG_W),
        .FRAC    (FRAC),
        .OUT_W   (OUT_W)
    ) u_rot_pair (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .a     (rot_a),
        .b     (rot_b),
        .sin_v (sin1_q),
        .cos_v (cos1_q),
        .r0    (rot_r0),
        .r1    (rot_r1)
    );

    assign ext_x = OUT_W'(x2_q);
    assign ext_y = OUT_W'(y2_q);
    assign ext_z = OUT_W'(z2_q);

    always_comb begin
        v1_d        = v1_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        z1_d        = z1_q;
        sin1_d      = sin1_q;
        cos1_d      = cos1_q;
        axis1_d     = axis1_q;
        tag1_d      = tag1_q;
        last1_d     = last1_q;
        v2_d        = v2_q;
        x2_d        = x2_q;
        y2_d        = y2_q;
        z2_d        = z2_q;
        axis2_d     = axis2_q;
        tag2_d      = tag2_q;
        last2_d     = last2_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_z_d     = out_z_q;
        out_tag_d   = out_tag_q;
        out_last_d  = out_last_q;
        if (adv) begin
            v1_d        = in_valid;
            x1_d        = in_x;
            y1_d        = in_y;
            z1_d        = in_z;
            sin1_d      = in_sin;
            cos1_d      = in_cos;
            axis1_d     = axis_e'(in_axis);
            tag1_d      = in_tag;
            last1_d     = in_last;
            v2_d        = v1_q;
            x2_d        = x1_q;
            y2_d        = y1_q;
            z2_d        = z1_q;
            axis2_d     = axis1_q;
            tag2_d      = tag1_q;
            last2_d     = last1_q;
            out_valid_d = v2_q;
            out_tag_d   = tag2_q;
            out_last_d  = last2_q;
            // rot_pair r0/r1 are ordered (a', b') of the pair the stage-1 mux chose
            case (axis2_q)
                AXIS_Z: begin
                    out_x_d = rot_r0;
                    out_y_d = rot_r1;
                    out_z_d = ext_z;
                end
                AXIS_X: begin
                    out_x_d = ext_x;
                    out_y_d = rot_r0;
                    out_z_d = rot_r1;
                end
                AXIS_Y: begin
                    out_x_d = rot_r1;
                    out_y_d = ext_y;
                    out_z_d = rot_r0;
                end
                default: begin
                    out_x_d = ext_x;
                    out_y_d = ext_y;
                    out_z_d = ext_z;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            x1_q        <= '0;
            y1_q        <= '0;
            z1_q        <= '0;
            sin1_q      <= '0;
            cos1_q      <= '0;
            axis1_q     <= AXIS_NONE;
            tag1_q      <= '0;
            last1_q     <= 1'b0;
            v2_q        <= 1'b0;
            x2_q        <= '0;
            y2_q        <= '0;
            z2_q        <= '0;
            axis2_q     <= AXIS_NONE;
            tag2_q      <= '0;
            last2_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
            out_tag_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            z1_q        <= z1_d;
            sin1_q      <= sin1_d;
            cos1_q      <= cos1_d;
            axis1_q     <= axis1_d;
            tag1_q      <= tag1_d;
            last1_q     <= last1_d;
            v2_q        <= v2_d;
            x2_q        <= x2_d;
            y2_q        <= y2_d;
            z2_q        <= z2_d;
            axis2_q     <= axis2_d;
            tag2_q      <= tag2_d;
            last2_q     <= last2_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
            out_tag_q   <= out_tag_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;
    assign out_tag   = out_tag_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_vertex_rotator.sv
// tb/tb_vertex_rotator.sv - directed self-checking bench for vertex_rotator
module tb_vertex_rotator;

    localparam int CW  = 8;
    localparam int TW  = 16;
    localparam int TGW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [CW-1:0] in_x, in_y, in_z;
    logic signed [TW-1:0] in_sin, in_cos;
    logic [1:0]           in_axis;
    logic [TGW-1:0]       in_tag;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [CW:0]   out_x, out_y, out_z;
    logic [TGW-1:0]       out_tag;
    logic                 out_last;

    int n_cmp = 0;
    int n_bad = 0;

    vertex_rotator #(
        .COORD_W (CW),
        .TRIG_W  (TW),
        .FRAC    (8),
        .TAG_W   (TGW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .in_sin    (in_sin),
        .in_cos    (in_cos),
        .in_axis   (in_axis),
        .in_tag    (in_tag),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z),
        .out_tag   (out_tag),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input int z, input int s, input int c,
                         input int axis, input int tag, input bit last);
        in_valid = 1'b1;
        in_x     = CW'(x);
        in_y     = CW'(y);
        in_z     = CW'(z);
        in_sin   = TW'(s);
        in_cos   = TW'(c);
        in_axis  = 2'(axis);
        in_tag   = TGW'(tag);
        in_last  = last;
    endtask

    // one isolated beat with out_ready high: accepted at edge 0, visible after edge 2
    task automatic run_beat(input string nm, input int x, input int y, input int z,
                            input int s, input int c, input int axis, input int tag,
                            input int ex, input int ey, input int ez);
        drive(x, y, z, s, c, axis, tag, 1'b0);
        #1;
        chk({nm, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        chk({nm, "_lat2"}, out_valid, 0);
        @(posedge clk); #1;
        chk({nm, "_lat3"}, out_valid, 1);
        chk({nm, "_x"}, out_x, ex);
        chk({nm, "_y"}, out_y, ey);
        chk({nm, "_z"}, out_z, ez);
        chk({nm, "_tag"}, out_tag, tag);
        @(posedge clk); #1;
        chk({nm, "_drain"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int got;
        int idx;
        bit have_prev;
        bit acc;
        logic signed [CW:0] prev_x;
        logic [TGW-1:0] prev_tag;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_x = '0; in_y = '0; in_z = '0; in_sin = '0; in_cos = '0;
        in_axis = '0; in_tag = '0; in_last = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_x", out_x, 0);
        chk("reset_out_y", out_y, 0);
        chk("reset_out_z", out_z, 0);
        chk("reset_out_tag", out_tag, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        run_beat("rotz", -2, 8, 3, 'h00C0, 'h00A0, 2, 1, -7, 4, 3);
        run_beat("rotx", 9, 0, -7, 'h00C0, 'h00A0, 0, 2, 9, 5, -4);
        run_beat("ident", -128, 127, 0, 'h00C0, 'h00A0, 3, 3, -128, 127, 0);
        run_beat("roty", 4, 5, 6, 'h0100, 'h0000, 1, 4, 6, 5, -4);
`ifdef VERTEX_ROTATOR_SAT_EN
        run_beat("limit", 127, 127, 0, 'h0180, 'h0180, 2, 5, 0, 255, 0);
`else
        run_beat("limit", 127, 127, 0, 'h0180, 'h0180, 2, 5, 0, -131, 0);
`endif

        // stall: six beats, out_ready low in cycles 2..6
        got = 0; idx = 0; have_prev = 1'b0; prev_x = '0; prev_tag = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            out_ready = !(c >= 2 && c <= 6);
            if (idx < 6)
                drive(idx * 3 - 5, idx, -idx, 0, 'h0100, 2, idx, idx == 5);
            else
                in_valid = 1'b0;
            @(negedge clk);
            if (c >= 3 && c <= 6)
                chk("stall_in_ready", in_ready, 0);
            if (have_prev) begin
                chk("stall_hold_x", out_x, prev_x);
                chk("stall_hold_tag", out_tag, prev_tag);
                chk("stall_hold_valid", out_valid, 1);
            end
            have_prev = out_valid && !out_ready;
            prev_x    = out_x;
            prev_tag  = out_tag;
            if (out_valid && out_ready) begin
                chk("stall_tag", out_tag, got);
                chk("stall_last", out_last, (got == 5) ? 1 : 0);
                chk("stall_x", out_x, got * 3 - 5);
                chk("stall_y", out_y, got);
                chk("stall_z", out_z, -got);
                if (got == 5)
                    chk("stall_last_cycle", c, 12);
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc)
                idx++;
        end
        chk("stall_count", got, 6);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;

        // reset with two beats in flight
        drive(1, 2, 3, 0, 'h0100, 2, 'h40, 1'b0);
        @(posedge clk); #1;
        drive(4, 5, 6, 0, 'h0100, 2, 'h41, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_in_ready_during", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready_after", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rst_no_ghost", out_valid, 0);
        end
        run_beat("post_rst", 10, -3, 7, 'h0000, 'h0100, 2, 'h42, 10, -3, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vertex_rotator.md
VERTEX_ROTATOR -- requirements
Module: vertex_rotator

Interface
REQ-001 The module SHALL have parameter COORD_W, default 8, giving the signed input coordinate width.
REQ-002 The module SHALL have parameter TRIG_W, default 16, giving the signed sin/cos width.
REQ-003 The module SHALL have parameter FRAC, default 8, giving the number of fractional bits in sin/cos.
REQ-004 The module SHALL have parameter TAG_W, default 8, giving the passthrough tag width; OUT_W SHALL be a localparam equal to COORD_W+1.
REQ-005 The module SHALL have one clock and a synchronous active-high reset, with ports as follows:
- clk  input  1  sole clock
- rst  input  1  synchronous, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when high with in_valid
- in_x, in_y, in_z  input  COORD_W each  signed vertex
- in_sin, in_cos  input  TRIG_W each  signed, FRAC fractional bits
- in_axis  input  2  rotation axis: 0=X, 1=Y, 2=Z, 3=identity
- in_tag  input  TAG_W  opaque vertex index
- in_last  input  1  last vertex of object
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accept
- out_x, out_y, out_z  output  OUT_W each  signed rotated vertex
- out_tag  output  TAG_W  copy of in_tag
- out_last  output  1  copy of in_last

Function
REQ-006 All in_* fields SHALL be sampled together on the cycle in_valid && in_ready; per-beat sin/cos/axis apply only to that beat.
REQ-007 The datapath SHALL be 3 stages (register inputs, multiply, add/round/limit); latency from acceptance to out_valid SHALL be exactly 3 cycles when out_ready is held high.
REQ-008 Throughput SHALL be one beat per cycle with out_ready high.
REQ-009 The pipeline SHALL advance when !out_valid || out_ready, else all stages hold; in_ready SHALL equal that advance condition.
REQ-010 While out_valid && !out_ready, out_* SHALL remain stable; beats SHALL never be dropped, duplicated or reordered.
REQ-011 Axis Z: x'=x*cos-y*sin, y'=x*sin+y*cos, z'=z.
REQ-012 Axis X: y'=y*cos-z*sin, z'=y*sin+z*cos, x'=x.
REQ-013 Axis Y: z'=z*cos-x*sin, x'=z*sin+x*cos, y'=y.
REQ-014 Axis 3: outputs SHALL be the sign-extended inputs.
REQ-015 Products SHALL be COORD_W+TRIG_W bits and sums COORD_W+TRIG_W+1 bits; results SHALL be rounded half-up by adding 2^(FRAC-1) and then arithmetic-shifted right by FRAC.
REQ-016 Unrotated axes SHALL be sign-extended to OUT_W without rounding.
REQ-017 out_tag/out_last SHALL travel with their beat through all stages.

Reset
REQ-018 Reset SHALL clear all stage valid bits; out_valid=0 on the cycle after rst is sampled high.
REQ-019 out_x/out_y/out_z/out_tag/out_last SHALL reset to 0.
REQ-020 Beats in flight at reset SHALL be discarded and never emitted; in_ready SHALL be 1 during and after reset.

Configuration
REQ-021 With macro VERTEX_ROTATOR_SAT_EN defined, a rounded result outside [-2^(OUT_W-1), 2^(OUT_W-1)-1] SHALL clamp to the nearest bound.
REQ-022 Without VERTEX_ROTATOR_SAT_EN, the rounded result SHALL be truncated to its low OUT_W bits (two's-complement wrap).

Structure
REQ-023 A shared package rotate_pkg SHALL hold the axis enum (AXIS_X, AXIS_Y, AXIS_Z, AXIS_NONE) and default width constants.
REQ-024 One sub-module, rot_pair, SHALL compute a single 2-D rotation (a*cos-b*sin, a*sin+b*cos) with rounding and limiting; it SHALL be instantiated once and fed by axis muxes.

Verification
REQ-025 Z rotation (-2,8,3), sin=0x00C0, cos=0x00A0, out_ready=1 -> (-7,4,3) exactly 3 cycles after acceptance.
REQ-026 X rotation (9,0,-7), same sin/cos -> (9,5,-4); identity axis (-128,127,0) -> (-128,127,0).
REQ-027 Z rotation (127,127,0), sin=cos=0x0180 -> SAT_EN: (0,255,0); without SAT_EN: (0,-131,0).
REQ-028 Six back-to-back beats with tags 0..5 (last on tag 5), out_ready low for cycles 2..6 -> in_ready drops once the pipe is full, outputs stable while stalled, tags 0..5 emerge in order, out_last only on tag 5.
REQ-029 rst pulsed for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, those tags never appear, and a new beat has 3-cycle latency afterward.
